// File: rtl/mem_access_pkg.sv
// Shared definitions for the load/store engine: request size codes, FSM
// states and the byte masks the single-port word RAM honours.
package mem_access_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_e;

    localparam logic [3:0] MASK_NONE    = 4'b0000;
    localparam logic [3:0] MASK_WORD    = 4'b1111;
    localparam logic [3:0] MASK_HALF_LO = 4'b0011;
    localparam logic [3:0] MASK_HALF_HI = 4'b1100;
    localparam logic [3:0] MASK_BYTE0   = 4'b0001;

    // Single-lane mask for a byte offset within a word.
    function automatic logic [3:0] lane_mask(input logic [1:0] off);
        return MASK_BYTE0 << off;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load-result extension.
// Ports:
//   data_i   - assembled load bytes, right-justified
//   size_i   - size code (byte/half/word)
//   signed_i - sign-extend byte and half results
//   data_o   - extended 32-bit result
module load_extend
    import mem_access_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    output logic [31:0] data_o
);

    always_comb begin
        data_o = data_i;
        case (size_e'(size_i))
            SZ_BYTE: data_o = {{24{signed_i & data_i[7]}}, data_i[7:0]};
            SZ_HALF: data_o = {{16{signed_i & data_i[15]}}, data_i[15:0]};
            default: data_o = data_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Initiator-side load/store engine for a single-port word RAM.
// Accepts byte-addressed sized requests, issues one RAM beat for aligned
// accesses and one byte beat per byte for misaligned ones, and returns
// extended load data on a valid/ready response channel.
// Ports:
//   clk, rst                 - clock, async active-high reset
//   req_valid/req_ready      - request handshake (ready only in IDLE)
//   req_we/size/signed/addr/wdata - request fields
//   rsp_valid/rsp_ready      - response handshake
//   rsp_rdata, rsp_err       - load result (0 for stores/errors), illegal size
//   mem_addr/op/mask/wdata   - RAM command, driven only in ACCESS
//   mem_rdata                - combinational RAM read data
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-3:0] mem_addr,
    output logic              mem_op,
    output logic [3:0]        mem_mask,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    state_e            state_q, state_d;
    logic              we_q, we_d;
    size_e             size_q, size_d;
    logic              signed_q, signed_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       data_q, data_d;
    logic              mis_q, mis_d;
    logic              err_q, err_d;
    logic [2:0]        nbeat_q, nbeat_d;
    logic [2:0]        k_q, k_d;

    logic [ADDR_W-1:0] beat_addr;
    logic [31:0]       ext_data;

    // Misaligned beats walk byte addresses a+k with natural modulo wrap.
    assign beat_addr = addr_q + ADDR_W'(k_q);

    load_extend u_ext (
        .data_i   (data_q),
        .size_i   (size_q),
        .signed_i (signed_q),
        .data_o   (ext_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            size_q   <= SZ_BYTE;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            data_q   <= '0;
            mis_q    <= 1'b0;
            err_q    <= 1'b0;
            nbeat_q  <= '0;
            k_q      <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            data_q   <= data_d;
            mis_q    <= mis_d;
            err_q    <= err_d;
            nbeat_q  <= nbeat_d;
            k_q      <= k_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        size_d    = size_q;
        signed_d  = signed_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        data_d    = data_q;
        mis_d     = mis_q;
        err_d     = err_q;
        nbeat_d   = nbeat_q;
        k_d       = k_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        mem_addr  = '0;
        mem_op    = 1'b0;
        mem_mask  = MASK_NONE;
        mem_wdata = '0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    we_d     = req_we;
                    size_d   = size_e'(req_size);
                    signed_d = req_signed;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    data_d   = '0;
                    k_d      = '0;
                    err_d    = 1'b0;
                    mis_d    = 1'b0;
                    state_d  = ACCESS;
                    case (size_e'(req_size))
                        SZ_BYTE: nbeat_d = 3'd1;
                        SZ_HALF: begin
                            mis_d   = req_addr[0];
                            nbeat_d = req_addr[0] ? 3'd2 : 3'd1;
                        end
                        SZ_WORD: begin
                            mis_d   = |req_addr[1:0];
                            nbeat_d = (|req_addr[1:0]) ? 3'd4 : 3'd1;
                        end
                        default: begin
                            nbeat_d = 3'd0;
                            err_d   = 1'b1;
                            state_d = RESP;
                        end
                    endcase
                end
            end

            ACCESS: begin
                mem_op = we_q;
                if (mis_q) begin
                    mem_addr  = beat_addr[ADDR_W-1:2];
                    mem_mask  = lane_mask(beat_addr[1:0]);
                    mem_wdata = {4{wdata_q[{k_q[1:0], 3'b000} +: 8]}};
                    if (!we_q)
                        data_d[{k_q[1:0], 3'b000} +: 8] =
                            mem_rdata[{beat_addr[1:0], 3'b000} +: 8];
                end else begin
                    mem_addr = addr_q[ADDR_W-1:2];
                    case (size_q)
                        SZ_BYTE: begin
                            mem_mask  = lane_mask(addr_q[1:0]);
                            mem_wdata = {4{wdata_q[7:0]}};
                        end
                        SZ_HALF: begin
                            mem_mask  = addr_q[1] ? MASK_HALF_HI : MASK_HALF_LO;
                            mem_wdata = {2{wdata_q[15:0]}};
                        end
                        default: begin
                            mem_mask  = MASK_WORD;
                            mem_wdata = wdata_q;
                        end
                    endcase
                    // Shift the addressed lane(s) down; bytes above the
                    // access size are discarded by the extender.
                    if (!we_q)
                        data_d = mem_rdata >> {addr_q[1:0], 3'b000};
                end
                k_d = k_q + 3'd1;
                if (k_q == nbeat_q - 3'd1)
                    state_d = RESP;
            end

            RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                rsp_rdata = (err_q || we_q) ? 32'd0 : ext_data;
                if (rsp_ready)
                    state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a word RAM model on the mem_* port, a byte-array
// reference memory, directed scenarios with literal expectations, then
// randomized traffic.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [13:0] mem_addr;
    logic        mem_op;
    logic [3:0]  mem_mask;
    logic [31:0] mem_wdata, mem_rdata;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] ram [0:16383];
    logic [7:0]  ref_mem [0:65535];
    logic        ram_clr;

    logic [13:0] obs_addr [0:3];
    logic [3:0]  obs_mask [0:3];

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_addr   (mem_addr),
        .mem_op     (mem_op),
        .mem_mask   (mem_mask),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Word RAM: combinational read, masked write at the rising edge.
    assign mem_rdata = ram[mem_addr];
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 16384; i++) ram[i] <= '0;
        end else if (mem_op) begin
            for (int l = 0; l < 4; l++)
                if (mem_mask[l]) ram[mem_addr][8*l +: 8] <= mem_wdata[8*l +: 8];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Invariants valid on every cycle outside reset.
    always @(negedge clk) begin
        if (!rst) begin
            vectors++;
            if (!(mem_mask inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                   4'b0011, 4'b1100, 4'b1111})) begin
                miscompares++;
                $display("FAIL legal_mask: got %b at %0t", mem_mask, $time);
            end
            if (rsp_valid) chk("ready_low_in_rsp", {31'd0, req_ready}, 32'd0);
        end
    end

    function automatic int nbytes(input logic [1:0] sz);
        case (sz)
            2'b00: return 1;
            2'b01: return 2;
            2'b10: return 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sgn,
                                             input logic [15:0] a);
        logic [31:0] v = '0;
        for (int i = 0; i < nbytes(sz); i++) begin
            logic [15:0] b = a + 16'(i);
            v[8*i +: 8] = ref_mem[b];
        end
        if (sz == 2'b00) return sgn ? 32'($signed(v[7:0])) : {24'd0, v[7:0]};
        if (sz == 2'b01) return sgn ? 32'($signed(v[15:0])) : {16'd0, v[15:0]};
        return v;
    endfunction

    // Caller is at a negedge with the DUT idle; returns at a negedge, idle.
    task automatic do_req(input logic we, input logic [1:0] sz, input logic sgn,
                          input logic [15:0] a, input logic [31:0] wd,
                          input int hold, output logic [31:0] got);
        int nb = nbytes(sz);
        bit alig = (sz == 2'b00) || (sz == 2'b01 && a[0] == 1'b0) ||
                   (sz == 2'b10 && a[1:0] == 2'b00);
        int nbeats = (sz == 2'b11) ? 0 : (alig ? 1 : nb);
        logic [31:0] exp_rd = (we || sz == 2'b11) ? 32'd0 : ref_load(sz, sgn, a);
        logic [31:0] held;

        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sgn;
        req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr = 16'($urandom); req_wdata = $urandom; req_we = ~we;

        for (int k = 0; k < nbeats; k++) begin
            logic [13:0] ea;
            logic [3:0]  em = '0;
            logic [31:0] ew;
            @(negedge clk);
            if (alig) begin
                ea = a[15:2];
                for (int i = 0; i < nb; i++) begin
                    logic [15:0] b = a + 16'(i);
                    em[b[1:0]] = 1'b1;
                end
                for (int l = 0; l < 4; l++) ew[8*l +: 8] = wd[8*((l - int'(a[1:0])) & (nb - 1)) +: 8];
            end else begin
                logic [15:0] b = a + 16'(k);
                ea = b[15:2];
                em[b[1:0]] = 1'b1;
                ew = {4{wd[8*k +: 8]}};
            end
            obs_addr[k] = mem_addr;
            obs_mask[k] = mem_mask;
            chk("beat_op", {31'd0, mem_op}, {31'd0, we});
            chk("beat_addr", {18'd0, mem_addr}, {18'd0, ea});
            chk("beat_mask", {28'd0, mem_mask}, {28'd0, em});
            if (we) chk("beat_wdata", mem_wdata, ew);
        end

        @(negedge clk);
        chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, sz == 2'b11});
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("rsp_mem_op", {31'd0, mem_op}, 32'd0);
        got = rsp_rdata;
        held = rsp_rdata;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("hold_rdata", rsp_rdata, held);
            chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
            chk("hold_mem_op", {31'd0, mem_op}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("post_rsp_valid", {31'd0, rsp_valid}, 32'd0);

        if (we && sz != 2'b11)
            for (int i = 0; i < nb; i++) begin
                logic [15:0] b = a + 16'(i);
                ref_mem[b] = wd[8*i +: 8];
            end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] g;
        for (int i = 0; i < 65536; i++) ref_mem[i] = 8'h00;
        rst = 1'b1; ram_clr = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mem_op", {31'd0, mem_op}, 32'd0);
        chk("rst_mem_mask", {28'd0, mem_mask}, 32'd0);
        chk("rst_mem_addr", {18'd0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        ram_clr = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // Aligned word store then load.
        do_req(1'b1, 2'b10, 1'b0, 16'h0010, 32'hDEADBEEF, 0, g);
        chk("lit_w_addr", {18'd0, obs_addr[0]}, 32'd4);
        chk("lit_w_mask", {28'd0, obs_mask[0]}, 32'hF);
        do_req(1'b0, 2'b10, 1'b0, 16'h0010, 32'h0, 1, g);
        chk("lit_w_load", g, 32'hDEADBEEF);

        // Byte store merging into a preloaded word.
        do_req(1'b1, 2'b10, 1'b0, 16'h0010, 32'h11223344, 0, g);
        do_req(1'b1, 2'b00, 1'b0, 16'h0012, 32'h000000AB, 0, g);
        chk("lit_b_mask", {28'd0, obs_mask[0]}, 32'h4);
        do_req(1'b0, 2'b10, 1'b0, 16'h0010, 32'h0, 0, g);
        chk("lit_b_merge", g, 32'h11AB3344);
        do_req(1'b0, 2'b00, 1'b1, 16'h0012, 32'h0, 0, g);
        chk("lit_b_signed", g, 32'hFFFFFFAB);
        do_req(1'b0, 2'b00, 1'b0, 16'h0012, 32'h0, 0, g);
        chk("lit_b_unsigned", g, 32'h000000AB);

        // Misaligned word.
        do_req(1'b1, 2'b10, 1'b0, 16'h0013, 32'hCAFEBABE, 0, g);
        chk("lit_m_a0", {18'd0, obs_addr[0]}, 32'd4);
        chk("lit_m_m0", {28'd0, obs_mask[0]}, 32'h8);
        chk("lit_m_a1", {18'd0, obs_addr[1]}, 32'd5);
        chk("lit_m_m1", {28'd0, obs_mask[1]}, 32'h1);
        chk("lit_m_m2", {28'd0, obs_mask[2]}, 32'h2);
        chk("lit_m_a3", {18'd0, obs_addr[3]}, 32'd5);
        chk("lit_m_m3", {28'd0, obs_mask[3]}, 32'h4);
        do_req(1'b0, 2'b10, 1'b0, 16'h0013, 32'h0, 0, g);
        chk("lit_m_load", g, 32'hCAFEBABE);

        // Address wrap-around.
        do_req(1'b1, 2'b01, 1'b0, 16'hFFFF, 32'h00001234, 0, g);
        chk("lit_wrap_a0", {18'd0, obs_addr[0]}, 32'd16383);
        chk("lit_wrap_m0", {28'd0, obs_mask[0]}, 32'h8);
        chk("lit_wrap_a1", {18'd0, obs_addr[1]}, 32'd0);
        chk("lit_wrap_m1", {28'd0, obs_mask[1]}, 32'h1);
        do_req(1'b0, 2'b01, 1'b1, 16'hFFFF, 32'h0, 0, g);
        chk("lit_wrap_load", g, 32'h00001234);

        // Illegal size under back-pressure.
        do_req(1'b1, 2'b11, 1'b0, 16'h0020, 32'hFFFFFFFF, 5, g);
        chk("lit_ill_rdata", g, 32'd0);

        // Reset during beat 1 of a misaligned word store.
        chk("rm_ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 16'h0021; req_wdata = 32'h55667788;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rm_beat0_mask", {28'd0, mem_mask}, 32'h2);
        @(negedge clk);
        chk("rm_beat1_op", {31'd0, mem_op}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rm_async_op", {31'd0, mem_op}, 32'd0);
        chk("rm_async_mask", {28'd0, mem_mask}, 32'd0);
        chk("rm_async_addr", {18'd0, mem_addr}, 32'd0);
        chk("rm_async_rsp", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ref_mem[16'h0021] = 8'h88;
        @(negedge clk);
        chk("rm_ready_after", {31'd0, req_ready}, 32'd1);
        chk("rm_no_rsp", {31'd0, rsp_valid}, 32'd0);
        do_req(1'b0, 2'b00, 1'b0, 16'h0021, 32'h0, 0, g);
        chk("lit_rm_byte0", g, 32'h00000088);
        do_req(1'b0, 2'b00, 1'b0, 16'h0022, 32'h0, 0, g);
        chk("lit_rm_byte1", g, 32'h00000000);
        do_req(1'b0, 2'b10, 1'b0, 16'h0021, 32'h0, 0, g);

        // Randomized traffic in two small windows, one straddling the wrap.
        for (int t = 0; t < 300; t++) begin
            logic [15:0] a = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 63))
                                                          : 16'hFFC0 + 16'($urandom_range(0, 63));
            logic [1:0]  sz = ($urandom_range(0, 9) == 9) ? 2'b11 : 2'($urandom_range(0, 2));
            do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
                   $urandom_range(0, 3), g);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
